// File: rtl/mul_float_param_pipe_pkg.sv
// Shared types and helpers for the parametrised floating-point multiplier.
//   rm_t     : run-time rounding mode encoding (matches the 2-bit RM input)
//   fflags_t : per-operation exception flags {invalid, overflow, underflow, inexact}
//   spec_t   : special-operand class decided in stage 1 and carried down the pipe
//   bias()   : exponent bias for a given exponent width
package mul_float_pkg;

    typedef enum logic [1:0] {
        RM_RNE = 2'd0,
        RM_RTZ = 2'd1,
        RM_RUP = 2'd2,
        RM_RDN = 2'd3
    } rm_t;

    typedef struct packed {
        logic invalid;
        logic overflow;
        logic underflow;
        logic inexact;
    } fflags_t;

    // nan: result is the canonical qNaN; invalid: raise the invalid flag with it;
    // inf / zero: result is a signed infinity / signed zero with no flags.
    typedef struct packed {
        logic nan;
        logic invalid;
        logic inf;
        logic zero;
    } spec_t;

    function automatic int bias(input int exp_w);
        return (32'sd1 <<< (exp_w - 32'sd1)) - 32'sd1;
    endfunction

endpackage

// File: rtl/mul_float_param_pipe_if.sv
// Handshake/data bundle of the floating-point multiplier.
//   Input side : iDATA_REQ / oDATA_BUSY with operands A, B, rounding mode and tag.
//   Output side: oDATA_VALID / iDATA_BUSY with product, flags and tag.
//   slave  : view of the multiplier itself.
//   master : view of the issuing/consuming logic (or a testbench).
interface mul_float_param_pipe_if #(
    parameter int EXP_W  = 8,
    parameter int FRAC_W = 23,
    parameter int TAG_W  = 4
);
    localparam int W = 1 + EXP_W + FRAC_W;

    logic             iDATA_REQ;
    logic             oDATA_BUSY;
    logic [W-1:0]     iDATA_A;
    logic [W-1:0]     iDATA_B;
    logic [1:0]       iDATA_RM;
    logic [TAG_W-1:0] iDATA_TAG;
    logic             oDATA_VALID;
    logic             iDATA_BUSY;
    logic [W-1:0]     oDATA;
    logic [3:0]       oDATA_FLAGS;
    logic [TAG_W-1:0] oDATA_TAG;

    modport slave (
        input  iDATA_REQ, iDATA_A, iDATA_B, iDATA_RM, iDATA_TAG, iDATA_BUSY,
        output oDATA_BUSY, oDATA_VALID, oDATA, oDATA_FLAGS, oDATA_TAG
    );

    modport master (
        output iDATA_REQ, iDATA_A, iDATA_B, iDATA_RM, iDATA_TAG, iDATA_BUSY,
        input  oDATA_BUSY, oDATA_VALID, oDATA, oDATA_FLAGS, oDATA_TAG
    );

endinterface

// File: rtl/mul_float_param_pipe_round.sv
// Rounding increment decision for the multiplier's final stage.
//   rm       : rounding mode
//   sign     : sign of the result
//   lsb      : least significant kept mantissa bit
//   guard    : first discarded bit
//   sticky   : OR of all further discarded bits
//   round_up : 1 when the kept mantissa must be incremented by one ulp
module mul_float_round
    import mul_float_pkg::*;
(
    input  rm_t  rm,
    input  logic sign,
    input  logic lsb,
    input  logic guard,
    input  logic sticky,
    output logic round_up
);

    // Pick the increment according to the directed/nearest rounding rule
    always_comb begin
        round_up = 1'b0;
        case (rm)
            RM_RNE:  round_up = guard && (sticky || lsb);
            RM_RTZ:  round_up = 1'b0;
            RM_RUP:  round_up = !sign && (guard || sticky);
            RM_RDN:  round_up = sign && (guard || sticky);
            default: round_up = 1'b0;
        endcase
    end

endmodule

// File: rtl/mul_float_param_pipe.sv
// Parametrised IEEE-754-style floating-point multiplier, 3-stage valid/busy pipeline.
//   iCLOCK      : clock, all state on posedge
//   iRESET_SYNC : synchronous active-high reset, discards everything in flight
//   bus         : slave side of mul_float_param_pipe_if (request, operands, rounding
//                 mode, tag in; product, flags, tag out; busy in both directions)
// Stage 1 classifies specials and sums exponents, stage 2 multiplies and normalises,
// stage 3 rounds, range-checks and registers the result. Denormal inputs are flushed
// to zero, results below the normal range flush to signed zero.
module mul_float_param_pipe
    import mul_float_pkg::*;
#(
    parameter int EXP_W  = 8,
    parameter int FRAC_W = 23,
    parameter int TAG_W  = 4
)(
    input  logic                   iCLOCK,
    input  logic                   iRESET_SYNC,
    mul_float_param_pipe_if.slave  bus
);

    localparam int W  = 1 + EXP_W + FRAC_W;
    localparam int M  = FRAC_W + 1;      // mantissa with hidden bit
    localparam int P  = 2 * M;           // full product width
    localparam int XW = EXP_W + 2;       // signed working exponent width

    localparam logic signed [XW-1:0] BIAS_X   = XW'(bias(EXP_W));
    localparam logic signed [XW-1:0] EXP_OVF  = XW'((32'sd1 <<< EXP_W) - 32'sd1);
    localparam logic signed [XW-1:0] EXP_ZERO = {XW{1'b0}};
    localparam logic [EXP_W-1:0]     EXP_ONES = {EXP_W{1'b1}};
    localparam logic [EXP_W-1:0]     EXP_MAXF = {{(EXP_W-1){1'b1}}, 1'b0};
    localparam logic [FRAC_W-1:0]    FRAC_0   = {FRAC_W{1'b0}};
    localparam logic [FRAC_W-1:0]    FRAC_1   = {FRAC_W{1'b1}};

    // ---------------- handshake ----------------
    logic v1_r, v2_r, v3_r;
    logic adv1_s, adv2_s, adv3_s;

    // A stage may load when it is empty or the stage after it is not stalled;
    // a full pipe with a stalled output therefore back-propagates to oDATA_BUSY.
    assign adv3_s = !v3_r || !bus.iDATA_BUSY;
    assign adv2_s = !v2_r || !(v3_r && !adv3_s);
    assign adv1_s = !v1_r || !(v2_r && !adv2_s);
    assign bus.oDATA_BUSY = v1_r && !adv1_s;

    // ---------------- stage 1: unpack / classify ----------------
    logic               sa_s, sb_s;
    logic [EXP_W-1:0]   ea_s, eb_s;
    logic [FRAC_W-1:0]  fa_s, fb_s;
    logic               a_zero_s, b_zero_s, a_inf_s, b_inf_s;
    logic               a_nan_s, b_nan_s, a_snan_s, b_snan_s, inf_zero_s;
    logic signed [XW-1:0] exp_sum_s;
    spec_t              spec_s;

    assign {sa_s, ea_s, fa_s} = bus.iDATA_A;
    assign {sb_s, eb_s, fb_s} = bus.iDATA_B;

    // exp == 0 covers denormals too: they are treated as zero
    assign a_zero_s   = (ea_s == {EXP_W{1'b0}});
    assign b_zero_s   = (eb_s == {EXP_W{1'b0}});
    assign a_inf_s    = (ea_s == EXP_ONES) && (fa_s == FRAC_0);
    assign b_inf_s    = (eb_s == EXP_ONES) && (fb_s == FRAC_0);
    assign a_nan_s    = (ea_s == EXP_ONES) && (fa_s != FRAC_0);
    assign b_nan_s    = (eb_s == EXP_ONES) && (fb_s != FRAC_0);
    assign a_snan_s   = a_nan_s && !fa_s[FRAC_W-1];
    assign b_snan_s   = b_nan_s && !fb_s[FRAC_W-1];
    assign inf_zero_s = (a_inf_s && b_zero_s) || (b_inf_s && a_zero_s);
    assign exp_sum_s  = $signed({2'b00, ea_s}) + $signed({2'b00, eb_s}) - BIAS_X;

    // Special-operand class in priority order: NaN / inf*0, then inf, then zero
    always_comb begin
        spec_s = spec_t'(4'b0000);
        if (a_nan_s || b_nan_s || inf_zero_s) begin
            spec_s.nan     = 1'b1;
            spec_s.invalid = inf_zero_s || a_snan_s || b_snan_s;
        end else if (a_inf_s || b_inf_s) begin
            spec_s.inf = 1'b1;
        end else if (a_zero_s || b_zero_s) begin
            spec_s.zero = 1'b1;
        end else begin
            spec_s = spec_t'(4'b0000);
        end
    end

    logic                 s1_sign_r;
    logic signed [XW-1:0] s1_exp_r;
    logic [M-1:0]         s1_ma_r, s1_mb_r;
    rm_t                  s1_rm_r;
    spec_t                s1_spec_r;
    logic [TAG_W-1:0]     s1_tag_r;

    // Stage 1 register: capture an accepted request, hold while stalled
    always_ff @(posedge iCLOCK) begin
        if (iRESET_SYNC) begin
            v1_r      <= 1'b0;
            s1_sign_r <= 1'b0;
            s1_exp_r  <= EXP_ZERO;
            s1_ma_r   <= {M{1'b0}};
            s1_mb_r   <= {M{1'b0}};
            s1_rm_r   <= RM_RNE;
            s1_spec_r <= spec_t'(4'b0000);
            s1_tag_r  <= {TAG_W{1'b0}};
        end else if (adv1_s) begin
            v1_r <= bus.iDATA_REQ;
            if (bus.iDATA_REQ) begin
                s1_sign_r <= sa_s ^ sb_s;
                s1_exp_r  <= exp_sum_s;
                s1_ma_r   <= {1'b1, fa_s};
                s1_mb_r   <= {1'b1, fb_s};
                s1_rm_r   <= rm_t'(bus.iDATA_RM);
                s1_spec_r <= spec_s;
                s1_tag_r  <= bus.iDATA_TAG;
            end
        end
    end

    // ---------------- stage 2: multiply / normalise ----------------
    logic [P-1:0]         prod_s, norm_s;
    logic signed [XW-1:0] exp2_s;

    assign prod_s = {{M{1'b0}}, s1_ma_r} * {{M{1'b0}}, s1_mb_r};
    // Product is in [1,4): a set MSB means [2,4) and bumps the exponent. The other
    // case is aligned by a left shift instead, so no product bit is ever dropped
    // before the sticky OR.
    assign norm_s = prod_s[P-1] ? prod_s : {prod_s[P-2:0], 1'b0};
    assign exp2_s = s1_exp_r + $signed({{(XW-1){1'b0}}, prod_s[P-1]});

    logic                 s2_sign_r;
    logic signed [XW-1:0] s2_exp_r;
    logic [M-1:0]         s2_mant_r;
    logic                 s2_guard_r, s2_sticky_r;
    rm_t                  s2_rm_r;
    spec_t                s2_spec_r;
    logic [TAG_W-1:0]     s2_tag_r;

    // Stage 2 register: keep mantissa, guard and sticky of the normalised product
    always_ff @(posedge iCLOCK) begin
        if (iRESET_SYNC) begin
            v2_r        <= 1'b0;
            s2_sign_r   <= 1'b0;
            s2_exp_r    <= EXP_ZERO;
            s2_mant_r   <= {M{1'b0}};
            s2_guard_r  <= 1'b0;
            s2_sticky_r <= 1'b0;
            s2_rm_r     <= RM_RNE;
            s2_spec_r   <= spec_t'(4'b0000);
            s2_tag_r    <= {TAG_W{1'b0}};
        end else if (adv2_s) begin
            v2_r <= v1_r;
            if (v1_r) begin
                s2_sign_r   <= s1_sign_r;
                s2_exp_r    <= exp2_s;
                s2_mant_r   <= norm_s[P-1 -: M];
                s2_guard_r  <= norm_s[FRAC_W];
                s2_sticky_r <= |norm_s[FRAC_W-1:0];
                s2_rm_r     <= s1_rm_r;
                s2_spec_r   <= s1_spec_r;
                s2_tag_r    <= s1_tag_r;
            end
        end
    end

    // ---------------- stage 3: round / range / specials ----------------
    logic                 round_up_s, carry_s, ovf_s, unf_s, ovf_inf_s;
    logic [M:0]           mant_rnd_s;
    logic [FRAC_W-1:0]    frac3_s;
    logic signed [XW-1:0] exp3_s;
    logic [W-1:0]         res_s;
    fflags_t              flags_s;

    mul_float_round u_round (
        .rm       (s2_rm_r),
        .sign     (s2_sign_r),
        .lsb      (s2_mant_r[0]),
        .guard    (s2_guard_r),
        .sticky   (s2_sticky_r),
        .round_up (round_up_s)
    );

    assign mant_rnd_s = {1'b0, s2_mant_r} + {{M{1'b0}}, round_up_s};
    // Rounding 1.11..1 up gives 10.00..0: fraction is zero and exponent grows
    assign carry_s = mant_rnd_s[M];
    assign frac3_s = carry_s ? mant_rnd_s[FRAC_W:1] : mant_rnd_s[FRAC_W-1:0];
    assign exp3_s  = s2_exp_r + $signed({{(XW-1){1'b0}}, carry_s});
    assign ovf_s   = (exp3_s >= EXP_OVF);
    assign unf_s   = (exp3_s <= EXP_ZERO);

    // Overflow saturates to max-finite unless the mode rounds away from zero
    always_comb begin
        ovf_inf_s = 1'b1;
        case (s2_rm_r)
            RM_RNE:  ovf_inf_s = 1'b1;
            RM_RTZ:  ovf_inf_s = 1'b0;
            RM_RUP:  ovf_inf_s = !s2_sign_r;
            RM_RDN:  ovf_inf_s = s2_sign_r;
            default: ovf_inf_s = 1'b1;
        endcase
    end

    // Final result selection: specials override, then overflow, underflow, normal
    always_comb begin
        res_s   = {W{1'b0}};
        flags_s = fflags_t'(4'b0000);
        if (s2_spec_r.nan) begin
            res_s           = {1'b0, EXP_ONES, 1'b1, {(FRAC_W-1){1'b0}}};
            flags_s.invalid = s2_spec_r.invalid;
        end else if (s2_spec_r.inf) begin
            res_s = {s2_sign_r, EXP_ONES, FRAC_0};
        end else if (s2_spec_r.zero) begin
            res_s = {s2_sign_r, {EXP_W{1'b0}}, FRAC_0};
        end else if (ovf_s) begin
            res_s            = ovf_inf_s ? {s2_sign_r, EXP_ONES, FRAC_0}
                                         : {s2_sign_r, EXP_MAXF, FRAC_1};
            flags_s.overflow = 1'b1;
            flags_s.inexact  = 1'b1;
        end else if (unf_s) begin
            res_s             = {s2_sign_r, {EXP_W{1'b0}}, FRAC_0};
            flags_s.underflow = 1'b1;
            flags_s.inexact   = 1'b1;
        end else begin
            res_s           = {s2_sign_r, exp3_s[EXP_W-1:0], frac3_s};
            flags_s.inexact = s2_guard_r || s2_sticky_r;
        end
    end

    logic [W-1:0]     out_data_r;
    fflags_t          out_flags_r;
    logic [TAG_W-1:0] out_tag_r;

    // Output register: result stays bit-stable while the consumer is busy
    always_ff @(posedge iCLOCK) begin
        if (iRESET_SYNC) begin
            v3_r        <= 1'b0;
            out_data_r  <= {W{1'b0}};
            out_flags_r <= fflags_t'(4'b0000);
            out_tag_r   <= {TAG_W{1'b0}};
        end else if (adv3_s) begin
            v3_r <= v2_r;
            if (v2_r) begin
                out_data_r  <= res_s;
                out_flags_r <= flags_s;
                out_tag_r   <= s2_tag_r;
            end
        end
    end

    assign bus.oDATA_VALID = v3_r;
    assign bus.oDATA       = out_data_r;
    assign bus.oDATA_FLAGS = out_flags_r;
    assign bus.oDATA_TAG   = out_tag_r;

endmodule
